// File: rtl/tick_divider_bank.sv
// tick_divider_bank: a bank of independent clock-enable generators.
// Each channel divides CLK by a runtime-programmable ratio. It emits a
// one-cycle tick per period and a near-50% divided square wave.
// Channels run continuously or one-shot. A divisor written mid-period is
// held in a shadow register and only takes effect at the next wrap.
module tick_divider_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10,
  localparam int SELW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] mode,
  input  logic                div_wr,
  input  logic [SELW-1:0]     div_sel,
  input  logic [WIDTH-1:0]    div_data,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } chan_state_e;

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // A zero divisor is meaningless, so it is stored as 1 on every path.
  logic [WIDTH-1:0] wr_data;
  assign wr_data = (div_data == '0) ? ONE : div_data;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic             tick_q, tick_d;
    logic             clko_q, clko_d;
    logic             wr;
    logic             wrap;
    chan_state_e      state;

    // Out-of-range selects match no channel and are silently dropped.
    assign wr    = div_wr && (div_sel == SELW'(c));
    assign state = !enable[c] ? ST_IDLE : (done_q ? ST_HALT : ST_RUN);
    assign wrap  = (cnt_q == (div_q - ONE));

    // Next-state logic: counting, divisor hand-over and one-shot halt.
    always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      done_d = done_q;
      tick_d = 1'b0;
      clko_d = 1'b0;
      case (state)
        ST_IDLE: begin
          // No period is in progress, so a divisor can be adopted at once.
          // A leftover shadow value is promoted so that it is not lost.
          cnt_d  = '0;
          done_d = 1'b0;
          pend_d = 1'b0;
          if (wr) begin
            div_d = wr_data;
            shd_d = wr_data;
          end else if (pend_q) begin
            div_d = shd_q;
          end
        end
        ST_RUN: begin
          if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            pend_d = 1'b0;
            if (wr) begin
              div_d = wr_data;
              shd_d = wr_data;
            end else if (pend_q) begin
              div_d = shd_q;
            end
            if (mode[c]) begin
              done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + ONE;
            if (wr) begin
              shd_d  = wr_data;
              pend_d = 1'b1;
            end
          end
          // The square wave uses the divisor that governs the new count.
          clko_d = (cnt_d < (div_d >> 1));
        end
        ST_HALT: begin
          // Halted one-shot: counter parked, writes apply directly.
          cnt_d = '0;
          if (wr) begin
            div_d = wr_data;
            shd_d = wr_data;
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end

    // Channel state registers, cleared asynchronously to the default divisor.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt_q  <= '0;
        div_q  <= DEF_DIV;
        shd_q  <= DEF_DIV;
        pend_q <= 1'b0;
        done_q <= 1'b0;
        tick_q <= 1'b0;
        clko_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        done_q <= done_d;
        tick_q <= tick_d;
        clko_q <= clko_d;
      end
    end

    assign tick[c]    = tick_q;
    assign clk_out[c] = clko_q;
    assign pending[c] = pend_q;
    assign done[c]    = done_q;
  end

endmodule

// File: tb/tb_tick_divider_bank.sv
// Directed testbench for tick_divider_bank: a 4-channel main instance
// plus a 3-channel instance for out-of-range select handling.
module tb_tick_divider_bank;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  enable, mode;
  logic        divWr;
  logic [1:0]  divSel;
  logic [15:0] divData;
  logic [3:0]  tick, clkOut, pending, done;

  logic [2:0]  enable3, mode3;
  logic        divWr3;
  logic [1:0]  divSel3;
  logic [15:0] divData3;
  logic [2:0]  tick3, clkOut3, pending3, done3;

  int checks = 0;
  int errors = 0;

  tick_divider_bank #(.CHANNELS(4), .WIDTH(16), .DEFAULT_DIV(10)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .mode(mode),
    .div_wr(divWr), .div_sel(divSel), .div_data(divData),
    .tick(tick), .clk_out(clkOut), .pending(pending), .done(done)
  );

  tick_divider_bank #(.CHANNELS(3), .WIDTH(16), .DEFAULT_DIV(10)) dut3 (
    .CLK(CLK), .RST(RST), .enable(enable3), .mode(mode3),
    .div_wr(divWr3), .div_sel(divSel3), .div_data(divData3),
    .tick(tick3), .clk_out(clkOut3), .pending(pending3), .done(done3)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    enable = '0; mode = '0; divWr = 1'b0; divSel = '0; divData = '0;
    enable3 = '0; mode3 = '0; divWr3 = 1'b0; divSel3 = '0; divData3 = '0;
    step(); step();
    checks++; if (tick !== 4'b0) begin errors++; $display("[TB] FAIL reset_tick got %b exp 0000", tick); end
    checks++; if (clkOut !== 4'b0) begin errors++; $display("[TB] FAIL reset_clkout got %b exp 0000", clkOut); end
    checks++; if (pending !== 4'b0) begin errors++; $display("[TB] FAIL reset_pending got %b exp 0000", pending); end
    checks++; if (done !== 4'b0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0000", done); end
    checks++; if (tick3 !== 3'b0) begin errors++; $display("[TB] FAIL reset_tick3 got %b exp 000", tick3); end
    RST = 1'b0;
    step();
  endtask

  task automatic test_continuous();
    logic expT, expC;
    enable = 4'b0001;
    for (int e = 1; e <= 30; e++) begin
      step();
      expT = (e % 10 == 0);
      expC = ((e % 10) < 5);
      checks++; if (tick[0] !== expT) begin errors++; $display("[TB] FAIL cont_tick e=%0d got %b exp %b", e, tick[0], expT); end
      checks++; if (clkOut[0] !== expC) begin errors++; $display("[TB] FAIL cont_clkout e=%0d got %b exp %b", e, clkOut[0], expC); end
    end
    checks++; if (pending !== 4'b0 || done !== 4'b0) begin errors++; $display("[TB] FAIL cont_flags got p=%b d=%b exp 0000", pending, done); end
    enable = 4'b0000;
    step();
    checks++; if (tick !== 4'b0 || clkOut !== 4'b0) begin errors++; $display("[TB] FAIL cont_disable got t=%b c=%b exp 0000", tick, clkOut); end
  endtask

  task automatic test_pending();
    logic expT, expC, expP;
    enable = 4'b0010;
    for (int e = 1; e <= 18; e++) begin
      if (e == 3) begin divWr = 1'b1; divSel = 2'd1; divData = 16'd4; end
      step();
      divWr = 1'b0;
      if (e >= 3) begin
        expP = (e < 10);
        expT = (e == 10 || e == 14 || e == 18);
        expC = (e < 10) ? (e < 5) : (((e - 10) % 4) < 2);
        checks++; if (pending[1] !== expP) begin errors++; $display("[TB] FAIL pend_flag e=%0d got %b exp %b", e, pending[1], expP); end
        checks++; if (tick[1] !== expT) begin errors++; $display("[TB] FAIL pend_tick e=%0d got %b exp %b", e, tick[1], expT); end
        checks++; if (clkOut[1] !== expC) begin errors++; $display("[TB] FAIL pend_clkout e=%0d got %b exp %b", e, clkOut[1], expC); end
      end
    end
    enable = 4'b0000;
    step();
  endtask

  task automatic test_zero_div();
    divWr = 1'b1; divSel = 2'd2; divData = 16'd0;
    step();
    divWr = 1'b0;
    checks++; if (pending[2] !== 1'b0) begin errors++; $display("[TB] FAIL zero_pending got %b exp 0", pending[2]); end
    enable = 4'b0100;
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++; if (tick[2] !== 1'b1) begin errors++; $display("[TB] FAIL zero_tick e=%0d got %b exp 1", e, tick[2]); end
      checks++; if (clkOut[2] !== 1'b0) begin errors++; $display("[TB] FAIL zero_clkout e=%0d got %b exp 0", e, clkOut[2]); end
    end
    enable = 4'b0000;
    step();
  endtask

  task automatic test_one_shot();
    logic expT, expD;
    divWr = 1'b1; divSel = 2'd3; divData = 16'd3;
    step();
    divWr = 1'b0;
    mode = 4'b1000;
    enable = 4'b1000;
    for (int e = 1; e <= 8; e++) begin
      step();
      expT = (e == 3);
      expD = (e >= 3);
      checks++; if (tick[3] !== expT) begin errors++; $display("[TB] FAIL shot_tick e=%0d got %b exp %b", e, tick[3], expT); end
      checks++; if (done[3] !== expD) begin errors++; $display("[TB] FAIL shot_done e=%0d got %b exp %b", e, done[3], expD); end
      if (e >= 4) begin
        checks++; if (clkOut[3] !== 1'b0) begin errors++; $display("[TB] FAIL shot_clkout e=%0d got %b exp 0", e, clkOut[3]); end
      end
    end
    enable = 4'b0000;
    step();
    checks++; if (done[3] !== 1'b0 || tick[3] !== 1'b0) begin errors++; $display("[TB] FAIL shot_rearm got d=%b t=%b exp 0 0", done[3], tick[3]); end
    enable = 4'b1000;
    for (int e = 1; e <= 5; e++) begin
      step();
      expT = (e == 3);
      expD = (e >= 3);
      checks++; if (tick[3] !== expT) begin errors++; $display("[TB] FAIL shot2_tick e=%0d got %b exp %b", e, tick[3], expT); end
      checks++; if (done[3] !== expD) begin errors++; $display("[TB] FAIL shot2_done e=%0d got %b exp %b", e, done[3], expD); end
    end
    enable = 4'b0000;
    mode = 4'b0000;
    step();
  endtask

  task automatic test_async_reset();
    logic [3:0] expT;
    // Divisors at this point: ch0=10, ch1=4, ch2=1, ch3=3 (one-shot).
    mode = 4'b1000;
    enable = 4'b1111;
    for (int e = 1; e <= 4; e++) begin
      if (e == 4) begin divWr = 1'b1; divSel = 2'd0; divData = 16'd7; end
      step();
      divWr = 1'b0;
    end
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_pending got %b exp 1", pending[0]); end
    checks++; if (done[3] !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_done got %b exp 1", done[3]); end
    checks++; if (tick[2] !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_tick got %b exp 1", tick[2]); end
    checks++; if (clkOut[0] !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_clkout got %b exp 1", clkOut[0]); end
    #2;
    RST = 1'b1;
    #1;
    checks++; if (tick !== 4'b0) begin errors++; $display("[TB] FAIL arst_tick got %b exp 0000", tick); end
    checks++; if (clkOut !== 4'b0) begin errors++; $display("[TB] FAIL arst_clkout got %b exp 0000", clkOut); end
    checks++; if (pending !== 4'b0) begin errors++; $display("[TB] FAIL arst_pending got %b exp 0000", pending); end
    checks++; if (done !== 4'b0) begin errors++; $display("[TB] FAIL arst_done got %b exp 0000", done); end
    enable = 4'b0000;
    mode = 4'b0000;
    step(); step();
    RST = 1'b0;
    enable = 4'b1111;
    for (int e = 1; e <= 12; e++) begin
      step();
      expT = (e == 10) ? 4'b1111 : 4'b0000;
      checks++; if (tick !== expT) begin errors++; $display("[TB] FAIL arst_after_tick e=%0d got %b exp %b", e, tick, expT); end
    end
    checks++; if (pending !== 4'b0) begin errors++; $display("[TB] FAIL arst_after_pending got %b exp 0000", pending); end
    enable = 4'b0000;
    step();
  endtask

  task automatic test_bad_sel();
    logic [2:0] expT;
    enable3 = 3'b111;
    for (int e = 1; e <= 11; e++) begin
      if (e == 3) begin divWr3 = 1'b1; divSel3 = 2'd3; divData3 = 16'd2; end
      step();
      divWr3 = 1'b0;
      expT = (e == 10) ? 3'b111 : 3'b000;
      checks++; if (pending3 !== 3'b000) begin errors++; $display("[TB] FAIL badsel_pending e=%0d got %b exp 000", e, pending3); end
      checks++; if (tick3 !== expT) begin errors++; $display("[TB] FAIL badsel_tick e=%0d got %b exp %b", e, tick3, expT); end
    end
    enable3 = 3'b000;
    step();
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_continuous();
    test_pending();
    test_zero_div();
    test_one_shot();
    test_async_reset();
    test_bad_sel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
